machine_ram_arbiter: RTL and testbench
======================================

MACHINE_RAM_ARBITER -- requirements
Module: machine_ram_arbiter

Interface
REQ-001 The block SHALL have parameter NCORES, default 4, meaning number of CPU request channels (2..16).
REQ-002 The block SHALL have parameter ADDR_W, default 30, meaning RAM word-pointer width.
REQ-003 The block SHALL have parameter DATA_W, default 64, meaning RAM data width.
REQ-004 The block SHALL have parameter RR, default 1, meaning 1 = round-robin and 0 = fixed priority with lowest index winning.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before an error is returned.
REQ-006 system1000  in  1  Single clock; all state SHALL update on its rising edge.
REQ-007 system1000_rst  in  1  Reset; synchronous, active-high.
REQ-008 req_valid  in  NCORES  Per-core request pending; the core holds the request stable until its req_ready pulse.
REQ-009 req_write  in  NCORES  Per-core operation: 1 = write, 0 = read.
REQ-010 req_addr  in  NCORES*ADDR_W  Packed per-core pointers; core i occupies slice [i*ADDR_W +: ADDR_W].
REQ-011 req_wdata  in  NCORES*DATA_W  Packed per-core write data.
REQ-012 core_done  in  NCORES  Core halted; while high, that core's requests SHALL be ignored.
REQ-013 req_ready  out  NCORES  One-cycle acceptance pulse, one-hot or zero.
REQ-014 rsp_status  out  2*NCORES  Per-core response: 00 none, 01 read data, 10 write ack, 11 error.
REQ-015 rsp_rdata  out  DATA_W  Read data; valid only when the granted core's status is 01; otherwise 0.
REQ-016 ram_req  out  2+ADDR_W+DATA_W  {valid, write, addr, wdata}.
REQ-017 ram_status  in  2+DATA_W  {code, rdata}: code 00 idle, 01 read done, 10 write done.
REQ-018 busy  out  1  High whenever the state is not IDLE.
REQ-019 err_count  out  8  Saturating count of error responses.

Function
REQ-020 The FSM SHALL have exactly four states, IDLE, ISSUE, WAIT and RESP, with all outputs registered.
REQ-021 In IDLE, with eligible = req_valid & ~core_done nonzero, the block SHALL select g, latch g and its write/addr/wdata, then go to ISSUE; with eligible zero it SHALL stay in IDLE.
REQ-022 When RR=1, g SHALL be the first eligible index searching upward from last_grant+1 modulo NCORES, and last_grant SHALL become g.
REQ-023 When RR=0, g SHALL be the lowest eligible index, and last_grant SHALL be unused.
REQ-024 In ISSUE, the block SHALL drive ram_req valid=1 with the latched fields and req_ready[g]=1 for exactly that one cycle, then go to WAIT.
REQ-025 Outside ISSUE, ram_req SHALL be all zero.
REQ-026 In WAIT, a nonzero ram_status code whose type matches the latched operation (01 for read, 10 for write) SHALL be captured (rdata on a read) and the FSM SHALL go to RESP.
REQ-027 In WAIT, a nonzero ram_status code whose type mismatches the latched operation SHALL be captured as error 11, and the FSM SHALL go to RESP.
REQ-028 A WAIT counter SHALL clear on entry and increment each WAIT cycle; when it reaches TIMEOUT with code still 00, the block SHALL capture error 11 and go to RESP.
REQ-029 ram_status SHALL be ignored in IDLE, ISSUE and RESP.
REQ-030 In RESP, for exactly one cycle, rsp_status[g] SHALL carry the captured code and all other channels SHALL be 00.
REQ-031 In RESP, rsp_rdata SHALL carry the captured data on a read-ok response and 0 otherwise, and the next state SHALL be IDLE.
REQ-032 In every state other than RESP, rsp_status SHALL be all 00 and rsp_rdata SHALL be 0.
REQ-033 Minimum accept-to-response latency: request seen in IDLE at cycle 0, ISSUE at cycle 1, ram response at cycle 2 at the earliest, rsp_status at cycle 3.
REQ-034 Only one transaction SHALL be outstanding at a time.
REQ-035 Back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-036 err_count SHALL increment on each RESP cycle with code 11 and saturate at 255.
REQ-037 core_done rising for core g after the grant SHALL NOT abort the transaction, and the response SHALL still be delivered.
REQ-038 When all eligible bits are 0, the block SHALL stay in IDLE with no output activity.

Reset
REQ-039 While system1000_rst is high at a clock edge, the next state SHALL be IDLE and last_grant SHALL be NCORES-1, so core 0 has first priority.
REQ-040 While system1000_rst is high at a clock edge, err_count, the WAIT counter, req_ready, rsp_status, rsp_rdata, ram_req and busy SHALL all be 0.
REQ-041 A reset asserted during ISSUE, WAIT or RESP SHALL abandon the transaction with no response delivered.
REQ-042 A ram_status code arriving after such a reset SHALL be ignored.

Verification
REQ-043 Single read: core 2 reads addr 0x5, RAM answers code 01 with data 0xDEAD_BEEF at cycle 2 -> req_ready=0b0100 at cycle 1; rsp_status[2]=01 and rsp_rdata=0xDEADBEEF at cycle 3.
REQ-044 Round-robin: all 4 cores request continuously, RAM acks each write after 1 cycle -> grant order 0,1,2,3,0; no core served twice before all others are served.
REQ-045 Fixed priority with RR=0: cores 1 and 3 request continuously -> core 1 always granted; core 3 never granted while core 1 stays valid.
REQ-046 Timeout with TIMEOUT=4: RAM never answers -> rsp_status[g]=11 after 4 WAIT cycles; err_count goes from 0 to 1.
REQ-047 Mismatch: a read is answered with code 10 -> rsp_status=11 and rsp_rdata=0.
REQ-048 Reset mid-WAIT, then RAM answers code 01 -> no rsp_status pulse; busy=0; the next grant goes to core 0.

Source files
------------

// File: rtl/machine_ram_arbiter.sv
// rtl/machine_ram_arbiter.sv - multi-core RAM arbiter, one transaction in flight
// Round-robin or fixed-priority grant, RAM timeout and status-mismatch error reporting.
module machine_ram_arbiter #(
    parameter int NCORES  = 4,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 64,
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                       system1000,
    input  logic                       system1000_rst,
    input  logic [NCORES-1:0]          req_valid,
    input  logic [NCORES-1:0]          req_write,
    input  logic [NCORES*ADDR_W-1:0]   req_addr,
    input  logic [NCORES*DATA_W-1:0]   req_wdata,
    input  logic [NCORES-1:0]          core_done,
    output logic [NCORES-1:0]          req_ready,
    output logic [2*NCORES-1:0]        rsp_status,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [2+ADDR_W+DATA_W-1:0] ram_req,
    input  logic [2+DATA_W-1:0]        ram_status,
    output logic                       busy,
    output logic [7:0]                 err_count
);

    localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  cur_idx;
    logic              cur_write;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        cap_code;

    logic [NCORES-1:0] eligible;
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic [1:0]          ram_code;
    logic [DATA_W-1:0]   ram_rdata;
    logic                code_match;
    logic                read_ok;
    logic [1:0]          rsp_code;
    logic [2*NCORES-1:0] rsp_status_nxt;

    assign eligible = req_valid & ~core_done;

    // Search starts one past the previous winner so every eligible core is reached within NCORES grants.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (RR != 0)
                cand = IDX_W'((int'(last_grant) + 1 + k) % NCORES);
            else
                cand = IDX_W'(k);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ram_code   = ram_status[DATA_W +: 2];
    assign ram_rdata  = ram_status[DATA_W-1:0];
    assign code_match = cur_write ? (ram_code == 2'b10) : (ram_code == 2'b01);
    assign read_ok    = code_match && !cur_write;
    // A silent RAM (timeout) and a wrong completion type both surface as error.
    assign rsp_code   = code_match ? ram_code : 2'b11;

    always_comb begin
        rsp_status_nxt = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (IDX_W'(i) == cur_idx)
                rsp_status_nxt[2*i +: 2] = rsp_code;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(NCORES - 1);
            cur_idx    <= '0;
            cur_write  <= 1'b0;
            wait_cnt   <= '0;
            cap_code   <= 2'b00;
            req_ready  <= '0;
            rsp_status <= '0;
            rsp_rdata  <= '0;
            ram_req    <= '0;
            busy       <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        state     <= ST_ISSUE;
                        busy      <= 1'b1;
                        cur_idx   <= grant_idx;
                        cur_write <= sel_write;
                        req_ready <= NCORES'(1) << grant_idx;
                        ram_req   <= {1'b1, sel_write, sel_addr, sel_wdata};
                        if (RR != 0)
                            last_grant <= grant_idx;
                    end
                end
                ST_ISSUE: begin
                    state     <= ST_WAIT;
                    req_ready <= '0;
                    ram_req   <= '0;
                    wait_cnt  <= '0;
                end
                ST_WAIT: begin
                    if (ram_code != 2'b00 || wait_cnt == CNT_LAST) begin
                        state      <= ST_RESP;
                        cap_code   <= rsp_code;
                        rsp_status <= rsp_status_nxt;
                        rsp_rdata  <= read_ok ? ram_rdata : '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    rsp_status <= '0;
                    rsp_rdata  <= '0;
                    if (cap_code == 2'b11 && err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_machine_ram_arbiter.sv
// tb/tb_machine_ram_arbiter.sv - directed self-checking bench for machine_ram_arbiter
module tb_machine_ram_arbiter;

    localparam int NC = 4;
    localparam int AW = 30;
    localparam int DW = 64;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC-1:0]     req_valid = '0;
    logic [NC-1:0]     req_write = '0;
    logic [NC-1:0]     core_done = '0;
    logic [NC*AW-1:0]  req_addr  = '0;
    logic [NC*DW-1:0]  req_wdata = '0;
    logic [2+DW-1:0]   ram_status = '0;

    logic [NC-1:0]     rr_ready,   fp_ready;
    logic [2*NC-1:0]   rr_rsp,     fp_rsp;
    logic [DW-1:0]     rr_rdata,   fp_rdata;
    logic [2+AW+DW-1:0] rr_ram_req, fp_ram_req;
    logic              rr_busy,    fp_busy;
    logic [7:0]        rr_err,     fp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    machine_ram_arbiter #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .RR(1), .TIMEOUT(TO)) dut_rr (
        .system1000(clk), .system1000_rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .core_done(core_done), .req_ready(rr_ready), .rsp_status(rr_rsp), .rsp_rdata(rr_rdata),
        .ram_req(rr_ram_req), .ram_status(ram_status), .busy(rr_busy), .err_count(rr_err)
    );

    machine_ram_arbiter #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .RR(0), .TIMEOUT(TO)) dut_fp (
        .system1000(clk), .system1000_rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .core_done(core_done), .req_ready(fp_ready), .rsp_status(fp_rsp), .rsp_rdata(fp_rdata),
        .ram_req(fp_ram_req), .ram_status(ram_status), .busy(fp_busy), .err_count(fp_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (rr_ready == '0 && n < 20);
    endtask

    function automatic logic [2+AW+DW-1:0] exp_req(input int i, input logic wr);
        return {1'b1, wr, req_addr[i*AW +: AW], req_wdata[i*DW +: DW]};
    endfunction

    task automatic serve(input int er, input int ef, input logic wr, input logic [DW-1:0] data);
        logic [1:0]      code;
        logic [NC-1:0]   rdy_r, rdy_f;
        logic [2*NC-1:0] st_r, st_f;
        logic [DW-1:0]   exp_data;
        code     = wr ? 2'b10 : 2'b01;
        rdy_r    = NC'(1) << er;
        rdy_f    = NC'(1) << ef;
        st_r     = (2*NC)'(code) << (2*er);
        st_f     = (2*NC)'(code) << (2*ef);
        exp_data = wr ? '0 : data;
        wait_grant();
        check("grant_rr", rr_ready, rdy_r);
        check("grant_fp", fp_ready, rdy_f);
        check("issue_rr", rr_ram_req, exp_req(er, wr));
        tick();
        ram_status = {code, exp_data};
        tick();
        ram_status = '0;
        check("rsp_rr", rr_rsp, st_r);
        check("rsp_fp", fp_rsp, st_f);
        check("rdata_rr", rr_rdata, exp_data);
        check("rdata_fp", fp_rdata, exp_data);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            req_addr[i*AW +: AW]  = AW'(16 + i);
            req_wdata[i*DW +: DW] = 64'hA0 + 64'(i);
        end

        // reset state
        tick();
        tick();
        check("rst_ready", rr_ready, 0);
        check("rst_rsp", rr_rsp, 0);
        check("rst_rdata", rr_rdata, 0);
        check("rst_ram_req", rr_ram_req, 0);
        check("rst_busy", rr_busy, 0);
        check("rst_err", rr_err, 0);
        check("rst_fp_busy", fp_busy, 0);
        rst = 1'b0;

        // single read by core 2 with minimum latency
        req_addr[2*AW +: AW] = 30'h5;
        req_valid = 4'b0100;
        req_write = 4'b0000;
        tick();
        check("rd_ready", rr_ready, 4'b0100);
        check("rd_ram_req", rr_ram_req, {1'b1, 1'b0, 30'h5, 64'hA2});
        check("rd_busy", rr_busy, 1);
        req_valid = 4'b0000;
        tick();
        check("rd_ram_idle", rr_ram_req, 0);
        check("rd_ready_clr", rr_ready, 0);
        check("rd_rsp_early", rr_rsp, 0);
        ram_status = {2'b01, 64'hDEAD_BEEF};
        tick();
        ram_status = '0;
        check("rd_status", rr_rsp, 8'h10);
        check("rd_rdata", rr_rdata, 64'hDEAD_BEEF);
        tick();
        check("rd_rsp_clr", rr_rsp, 0);
        check("rd_rdata_clr", rr_rdata, 0);
        check("rd_busy_clr", rr_busy, 0);
        req_addr[2*AW +: AW] = AW'(18);

        // round-robin with all cores writing continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        req_write = 4'b1111;
        serve(0, 0, 1'b1, 64'h0);
        serve(1, 0, 1'b1, 64'h0);
        serve(2, 0, 1'b1, 64'h0);
        serve(3, 0, 1'b1, 64'h0);
        serve(0, 0, 1'b1, 64'h0);

        // cores 1 and 3 reading: fixed priority always picks 1
        req_valid = 4'b1010;
        req_write = 4'b0000;
        serve(1, 1, 1'b0, 64'h1111_2222_3333_4444);
        serve(3, 1, 1'b0, 64'h5555_6666_7777_8888);
        serve(1, 1, 1'b0, 64'h0123_4567_89AB_CDEF);

        // timeout: RAM never answers
        req_valid = 4'b0001;
        wait_grant();
        check("to_ready", rr_ready, 4'b0001);
        req_valid = 4'b0000;
        for (int k = 0; k < TO; k++) begin
            tick();
            check("to_wait_rsp", rr_rsp, 0);
            check("to_wait_busy", rr_busy, 1);
        end
        tick();
        check("to_status", rr_rsp, 8'h03);
        check("to_status_fp", fp_rsp, 8'h03);
        check("to_rdata", rr_rdata, 0);
        check("to_err_pre", rr_err, 0);
        tick();
        check("to_err", rr_err, 1);
        check("to_rsp_clr", rr_rsp, 0);

        // read answered with a write completion
        req_valid = 4'b0010;
        wait_grant();
        check("mm_ready", rr_ready, 4'b0010);
        req_valid = 4'b0000;
        tick();
        ram_status = {2'b10, 64'h1234};
        tick();
        ram_status = '0;
        check("mm_status", rr_rsp, 8'h0C);
        check("mm_rdata", rr_rdata, 0);
        tick();
        check("mm_err", rr_err, 2);
        check("mm_err_fp", fp_err, 2);

        // halted core is masked; halting after grant still completes
        req_valid = 4'b1001;
        req_write = 4'b1000;
        core_done = 4'b0001;
        wait_grant();
        check("done_ready_rr", rr_ready, 4'b1000);
        check("done_ready_fp", fp_ready, 4'b1000);
        check("done_issue", rr_ram_req, exp_req(3, 1'b1));
        core_done = 4'b1001;
        tick();
        ram_status = {2'b10, 64'h0};
        tick();
        ram_status = '0;
        check("done_status", rr_rsp, 8'h80);
        check("done_status_fp", fp_rsp, 8'h80);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("masked_ready", rr_ready | fp_ready, 0);
            check("masked_busy", rr_busy | fp_busy, 0);
            check("masked_ram_req", rr_ram_req, 0);
        end

        // reset during WAIT abandons the transaction
        core_done = 4'b0000;
        req_valid = 4'b0010;
        req_write = 4'b0000;
        wait_grant();
        check("rw_ready", rr_ready, 4'b0010);
        req_valid = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_busy", rr_busy, 0);
        check("rw_err", rr_err, 0);
        ram_status = {2'b01, 64'hCAFE};
        tick();
        check("rw_rsp", rr_rsp | fp_rsp, 0);
        check("rw_busy2", rr_busy, 0);
        ram_status = '0;
        tick();
        check("rw_rsp2", rr_rsp | fp_rsp, 0);
        req_valid = 4'b1011;
        serve(0, 0, 1'b0, 64'h5555_AAAA_5555_AAAA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
